// File: rtl/rmt_pkt_pkg.sv
// Shared types and header-field constants for the RMT ingress packet path.
package rmt_pkt_pkg;

   // Destination class of a packet, decided from its first beat
   typedef enum logic [1:0] {
      CLS_DATA = 2'd0,
      CLS_CTRL = 2'd1,
      CLS_DROP = 2'd2
   } pkt_class_t;

   // Ingress steering state: between packets, forwarding one, or discarding one
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_DROP = 2'd2
   } ingress_state_t;

   // Byte offsets into the first beat (network byte order)
   localparam int OFF_TPID      = 12;
   localparam int OFF_TCI       = 14;
   localparam int OFF_ETYPE     = 16;
   localparam int OFF_PROTO     = 27;
   localparam int OFF_UDP_DPORT = 40;

   // Every byte up to and including the UDP dst port must be present
   localparam int HDR_BYTES = OFF_UDP_DPORT + 2;

   localparam logic [15:0] TPID_VLAN  = 16'h8100;
   localparam logic [15:0] ETYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  PROTO_UDP  = 8'h11;

endpackage

// File: rtl/pkt_hdr_classify.sv
// Combinational first-beat classifier: VLAN-tagged IPv4/UDP frames go to the
// control or data path depending on the UDP dst port, everything else drops.
module pkt_hdr_classify
   import rmt_pkt_pkg::*;
#(
   parameter int          DW            = 512,
   parameter logic [15:0] CTRL_UDP_PORT = 16'hF1F2
) (
   input  logic [DW-1:0]   tdata,
   input  logic [DW/8-1:0] tkeep,
   output pkt_class_t      pkt_class
);

   logic [15:0] tpid;
   logic [15:0] etype;
   logic [7:0]  proto;
   logic [15:0] dport;
   logic        unused_bits;

   // Multi-byte fields: lower byte index is the most significant byte
   assign tpid  = {tdata[8*OFF_TPID +: 8],      tdata[8*(OFF_TPID+1) +: 8]};
   assign etype = {tdata[8*OFF_ETYPE +: 8],     tdata[8*(OFF_ETYPE+1) +: 8]};
   assign proto = tdata[8*OFF_PROTO +: 8];
   assign dport = {tdata[8*OFF_UDP_DPORT +: 8], tdata[8*(OFF_UDP_DPORT+1) +: 8]};

   // Payload bytes and trailing byte enables play no part in the decision
   assign unused_bits = ^{tdata, tkeep};

   // Drop checks first, then control-port match, otherwise plain data
   always_comb begin
      // NOTE: default assignment first so no path leaves pkt_class unassigned (no latch).
      pkt_class = CLS_DATA;
      if (!(&tkeep[HDR_BYTES-1:0]) || tpid != TPID_VLAN ||
          etype != ETYPE_IPV4 || proto != PROTO_UDP) begin
         pkt_class = CLS_DROP;
      end else if (dport == CTRL_UDP_PORT) begin
         pkt_class = CLS_CTRL;
      end
   end

endmodule

// File: rtl/pkt_ingress_classifier.sv
// Ingress stage ahead of rmt_wrapper: steers whole AXIS packets to the control
// or data output (or drops them) based on the first beat, through one shared
// output register, and keeps saturating per-class packet counters.
module pkt_ingress_classifier
   import rmt_pkt_pkg::*;
#(
   parameter int          C_S_AXIS_DATA_WIDTH  = 512,
   parameter int          C_S_AXIS_TUSER_WIDTH = 128,
   parameter logic [15:0] CTRL_UDP_PORT        = 16'hF1F2,
   parameter int          CNT_WIDTH            = 32
) (
   input  logic                              clk,
   input  logic                              aresetn,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic                              s_axis_tlast,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_data_axis_tdata,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_data_axis_tkeep,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_data_axis_tuser,
   output logic                              m_data_axis_tvalid,
   output logic                              m_data_axis_tlast,
   input  logic                              m_data_axis_tready,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_ctrl_axis_tdata,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_ctrl_axis_tkeep,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_ctrl_axis_tuser,
   output logic                              m_ctrl_axis_tvalid,
   output logic                              m_ctrl_axis_tlast,
   input  logic                              m_ctrl_axis_tready,
   output logic [CNT_WIDTH-1:0]              ctrl_pkt_cnt,
   output logic [CNT_WIDTH-1:0]              data_pkt_cnt,
   output logic [CNT_WIDTH-1:0]              drop_pkt_cnt
);

   localparam int DW = C_S_AXIS_DATA_WIDTH;
   localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
   localparam int UW = C_S_AXIS_TUSER_WIDTH;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   ingress_state_t       state_q, state_d;
   pkt_class_t           dst_q, dst_d;
   logic                 vld_q, vld_d;
   logic                 last_q, last_d;
   logic [DW-1:0]        data_q, data_d;
   logic [KW-1:0]        keep_q, keep_d;
   logic [UW-1:0]        user_q, user_d;
   logic [CNT_WIDTH-1:0] ctrl_cnt_q, ctrl_cnt_d;
   logic [CNT_WIDTH-1:0] data_cnt_q, data_cnt_d;
   logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

   pkt_class_t hdr_cls;
   logic       sel_tready;
   logic       accept;
   logic       first_beat;
   logic       load;

   pkt_hdr_classify #(
      .DW            (DW),
      .CTRL_UDP_PORT (CTRL_UDP_PORT)
   ) u_hdr_classify (
      .tdata     (s_axis_tdata),
      .tkeep     (s_axis_tkeep),
      .pkt_class (hdr_cls)
   );

   // Handshake decisions: input ready, beat acceptance and output-register load
   always_comb begin
      sel_tready = (dst_q == CLS_CTRL) ? m_ctrl_axis_tready : m_data_axis_tready;
      if (!aresetn) begin
         s_axis_tready = 1'b0;
      end else if (state_q == ST_DROP) begin
         s_axis_tready = 1'b1;
      end else begin
         s_axis_tready = !vld_q || sel_tready;
      end
      accept     = s_axis_tvalid && s_axis_tready;
      first_beat = accept && (state_q == ST_IDLE);
      load       = accept && ((state_q == ST_FWD) || (first_beat && hdr_cls != CLS_DROP));
   end

   // Next-state for FSM, shared output register and saturating counters
   always_comb begin
      state_d    = state_q;
      dst_d      = dst_q;
      vld_d      = vld_q;
      last_d     = last_q;
      data_d     = data_q;
      keep_d     = keep_q;
      user_d     = user_q;
      ctrl_cnt_d = ctrl_cnt_q;
      data_cnt_d = data_cnt_q;
      drop_cnt_d = drop_cnt_q;

      // A drain and a load in the same cycle leave the new beat in the register
      if (vld_q && sel_tready) begin
         vld_d = 1'b0;
      end
      if (load) begin
         vld_d  = 1'b1;
         data_d = s_axis_tdata;
         keep_d = s_axis_tkeep;
         user_d = s_axis_tuser;
         last_d = s_axis_tlast;
         dst_d  = (state_q == ST_FWD) ? dst_q : hdr_cls;
      end

      if (accept) begin
         if (state_q == ST_IDLE) begin
            if (!s_axis_tlast) begin
               state_d = (hdr_cls == CLS_DROP) ? ST_DROP : ST_FWD;
            end
         end else if (s_axis_tlast) begin
            state_d = ST_IDLE;
         end
      end

      if (first_beat) begin
         if (hdr_cls == CLS_CTRL && !(&ctrl_cnt_q)) ctrl_cnt_d = ctrl_cnt_q + CNT_ONE;
         if (hdr_cls == CLS_DATA && !(&data_cnt_q)) data_cnt_d = data_cnt_q + CNT_ONE;
         if (hdr_cls == CLS_DROP && !(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + CNT_ONE;
      end
   end

   // State and datapath registers, cleared as soon as aresetn falls
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= ST_IDLE;
         dst_q      <= CLS_DATA;
         vld_q      <= 1'b0;
         last_q     <= 1'b0;
         // NOTE: the data register is reset too, so every output reads 0 during reset.
         data_q     <= '0;
         keep_q     <= '0;
         user_q     <= '0;
         ctrl_cnt_q <= '0;
         data_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so all flops update from pre-edge values.
         state_q    <= state_d;
         dst_q      <= dst_d;
         vld_q      <= vld_d;
         last_q     <= last_d;
         data_q     <= data_d;
         keep_q     <= keep_d;
         user_q     <= user_d;
         ctrl_cnt_q <= ctrl_cnt_d;
         data_cnt_q <= data_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign m_ctrl_axis_tvalid = vld_q && (dst_q == CLS_CTRL);
   assign m_data_axis_tvalid = vld_q && (dst_q == CLS_DATA);

   assign m_ctrl_axis_tdata  = data_q;
   assign m_ctrl_axis_tkeep  = keep_q;
   assign m_ctrl_axis_tuser  = user_q;
   assign m_ctrl_axis_tlast  = last_q;
   assign m_data_axis_tdata  = data_q;
   assign m_data_axis_tkeep  = keep_q;
   assign m_data_axis_tuser  = user_q;
   assign m_data_axis_tlast  = last_q;

   assign ctrl_pkt_cnt = ctrl_cnt_q;
   assign data_pkt_cnt = data_cnt_q;
   assign drop_pkt_cnt = drop_cnt_q;

endmodule

// File: tb/tb_pkt_ingress_classifier.sv
// Scoreboard bench for pkt_ingress_classifier: expected output beats are queued
// when accepted on the input and compared as they leave either output.
module tb_pkt_ingress_classifier;
   import rmt_pkt_pkg::*;

   localparam int DW = 512;
   localparam int KW = DW / 8;
   localparam int UW = 128;
   localparam int CW = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   typedef struct {
      logic          is_ctrl;
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic [UW-1:0] user;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] s_axis_tdata;
   logic [KW-1:0] s_axis_tkeep;
   logic [UW-1:0] s_axis_tuser;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic          s_axis_tlast;
   logic [DW-1:0] m_data_axis_tdata;
   logic [KW-1:0] m_data_axis_tkeep;
   logic [UW-1:0] m_data_axis_tuser;
   logic          m_data_axis_tvalid;
   logic          m_data_axis_tlast;
   logic          m_data_axis_tready;
   logic [DW-1:0] m_ctrl_axis_tdata;
   logic [KW-1:0] m_ctrl_axis_tkeep;
   logic [UW-1:0] m_ctrl_axis_tuser;
   logic          m_ctrl_axis_tvalid;
   logic          m_ctrl_axis_tlast;
   logic          m_ctrl_axis_tready;
   logic [CW-1:0] ctrl_pkt_cnt;
   logic [CW-1:0] data_pkt_cnt;
   logic [CW-1:0] drop_pkt_cnt;

   int    checks = 0;
   int    errors = 0;
   beat_t exp_q[$];
   int    exp_ctrl = 0;
   int    exp_data = 0;
   int    exp_drop = 0;

   always #5 clk = ~clk;

   pkt_ingress_classifier #(
      .C_S_AXIS_DATA_WIDTH  (DW),
      .C_S_AXIS_TUSER_WIDTH (UW),
      .CTRL_UDP_PORT        (16'hF1F2),
      .CNT_WIDTH            (CW)
   ) dut (
      .clk                (clk),
      .aresetn            (rst_n),
      .s_axis_tdata       (s_axis_tdata),
      .s_axis_tkeep       (s_axis_tkeep),
      .s_axis_tuser       (s_axis_tuser),
      .s_axis_tvalid      (s_axis_tvalid),
      .s_axis_tready      (s_axis_tready),
      .s_axis_tlast       (s_axis_tlast),
      .m_data_axis_tdata  (m_data_axis_tdata),
      .m_data_axis_tkeep  (m_data_axis_tkeep),
      .m_data_axis_tuser  (m_data_axis_tuser),
      .m_data_axis_tvalid (m_data_axis_tvalid),
      .m_data_axis_tlast  (m_data_axis_tlast),
      .m_data_axis_tready (m_data_axis_tready),
      .m_ctrl_axis_tdata  (m_ctrl_axis_tdata),
      .m_ctrl_axis_tkeep  (m_ctrl_axis_tkeep),
      .m_ctrl_axis_tuser  (m_ctrl_axis_tuser),
      .m_ctrl_axis_tvalid (m_ctrl_axis_tvalid),
      .m_ctrl_axis_tlast  (m_ctrl_axis_tlast),
      .m_ctrl_axis_tready (m_ctrl_axis_tready),
      .ctrl_pkt_cnt       (ctrl_pkt_cnt),
      .data_pkt_cnt       (data_pkt_cnt),
      .drop_pkt_cnt       (drop_pkt_cnt)
   );

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v >= CNT_MAX) ? CNT_MAX : v + 1;
   endfunction

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom();
      return d;
   endfunction

   function automatic logic [UW-1:0] rand_user();
      logic [UW-1:0] u;
      for (int i = 0; i < UW / 32; i++) u[32*i +: 32] = $urandom();
      return u;
   endfunction

   // First beat with the given header fields over a random payload
   function automatic logic [DW-1:0] make_hdr(input logic [15:0] tpid, input logic [15:0] etype,
                                              input logic [7:0] proto, input logic [15:0] port,
                                              input logic [11:0] vid);
      logic [DW-1:0] d;
      d = rand_data();
      d[8*12 +: 8] = tpid[15:8];
      d[8*13 +: 8] = tpid[7:0];
      d[8*14 +: 8] = {4'h0, vid[11:8]};
      d[8*15 +: 8] = vid[7:0];
      d[8*16 +: 8] = etype[15:8];
      d[8*17 +: 8] = etype[7:0];
      d[8*27 +: 8] = proto;
      d[8*40 +: 8] = port[15:8];
      d[8*41 +: 8] = port[7:0];
      return d;
   endfunction

   // Present one beat (called at posedge+1); returns at posedge+1 after acceptance
   task automatic send_beat(input beat_t b, input bit expect_out, output int waits);
      bit ok;
      ok    = 1'b0;
      waits = 0;
      s_axis_tdata  = b.data;
      s_axis_tkeep  = b.keep;
      s_axis_tuser  = b.user;
      s_axis_tlast  = b.last;
      s_axis_tvalid = 1'b1;
      while (!ok && waits <= 50) begin
         @(negedge clk);
         if (s_axis_tready) ok = 1'b1;
         else waits++;
      end
      if (!ok) check("accept_timeout", 1'b0, 1'b1);
      else if (expect_out) exp_q.push_back(b);
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
   endtask

   task automatic send_pkt(input logic [15:0] tpid, input logic [15:0] etype, input logic [7:0] proto,
                           input logic [15:0] port, input logic [11:0] vid, input int nbeats,
                           input pkt_class_t cls, output int max_wait);
      beat_t b;
      int    w;
      max_wait = 0;
      for (int i = 0; i < nbeats; i++) begin
         b.is_ctrl = (cls == CLS_CTRL);
         b.data    = (i == 0) ? make_hdr(tpid, etype, proto, port, vid) : rand_data();
         b.keep    = (i == nbeats - 1 && i != 0) ? 64'h0000_0000_0000_FFFF : '1;
         b.user    = rand_user();
         b.last    = (i == nbeats - 1);
         send_beat(b, cls != CLS_DROP, w);
         if (w > max_wait) max_wait = w;
         if (i == 0) begin
            case (cls)
               CLS_CTRL: exp_ctrl = sat_inc(exp_ctrl);
               CLS_DATA: exp_data = sat_inc(exp_data);
               default:  exp_drop = sat_inc(exp_drop);
            endcase
         end
      end
   endtask

   task automatic check_counters(input string tag);
      check({tag, "_ctrl_cnt"}, ctrl_pkt_cnt, exp_ctrl);
      check({tag, "_data_cnt"}, data_pkt_cnt, exp_data);
      check({tag, "_drop_cnt"}, drop_pkt_cnt, exp_drop);
   endtask

   // Output monitor: pops the scoreboard on each transfer, checks hold stability
   initial begin : monitor
      beat_t cur;
      beat_t held;
      beat_t e;
      bit    stalled;
      bit    rdy;
      stalled = 1'b0;
      forever begin
         @(negedge clk);
         if (m_ctrl_axis_tvalid && m_data_axis_tvalid) check("both_valid", 1'b1, 1'b0);
         if (m_ctrl_axis_tvalid || m_data_axis_tvalid) begin
            cur.is_ctrl = m_ctrl_axis_tvalid;
            cur.data    = cur.is_ctrl ? m_ctrl_axis_tdata : m_data_axis_tdata;
            cur.keep    = cur.is_ctrl ? m_ctrl_axis_tkeep : m_data_axis_tkeep;
            cur.user    = cur.is_ctrl ? m_ctrl_axis_tuser : m_data_axis_tuser;
            cur.last    = cur.is_ctrl ? m_ctrl_axis_tlast : m_data_axis_tlast;
            if (stalled) begin
               check("stable_dst", cur.is_ctrl, held.is_ctrl);
               check("stable_data", cur.data, held.data);
               check("stable_keep", cur.keep, held.keep);
               check("stable_user", cur.user, held.user);
               check("stable_last", cur.last, held.last);
            end
            rdy = cur.is_ctrl ? m_ctrl_axis_tready : m_data_axis_tready;
            if (rdy) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_beat", 1'b1, 1'b0);
               end else begin
                  e = exp_q.pop_front();
                  check("out_dst", cur.is_ctrl, e.is_ctrl);
                  check("out_data", cur.data, e.data);
                  check("out_keep", cur.keep, e.keep);
                  check("out_user", cur.user, e.user);
                  check("out_last", cur.last, e.last);
               end
               stalled = 1'b0;
            end else begin
               held    = cur;
               stalled = 1'b1;
            end
         end else begin
            stalled = 1'b0;
         end
      end
   end

   initial begin : main
      int    w;
      int    t;
      beat_t b;

      rst_n              = 1'b0;
      s_axis_tvalid      = 1'b0;
      s_axis_tdata       = '0;
      s_axis_tkeep       = '0;
      s_axis_tuser       = '0;
      s_axis_tlast       = 1'b0;
      m_ctrl_axis_tready = 1'b1;
      m_data_axis_tready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_s_tready", s_axis_tready, 1'b0);
      check("rst_ctrl_vld", m_ctrl_axis_tvalid, 1'b0);
      check("rst_data_vld", m_data_axis_tvalid, 1'b0);
      check("rst_data", m_data_axis_tdata, '0);
      check_counters("rst");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("idle_s_tready", s_axis_tready, 1'b1);

      // 1: two-beat control packet
      send_pkt(16'h8100, 16'h0800, 8'h11, 16'hF1F2, 12'd5, 2, CLS_CTRL, w);
      check_counters("t1");

      // 2: single-beat data packet, one-cycle latency
      send_pkt(16'h8100, 16'h0800, 8'h11, 16'h10E1, 12'd1, 1, CLS_DATA, w);
      @(negedge clk);
      check("t2_latency", m_data_axis_tvalid, 1'b1);
      check("t2_no_ctrl", m_ctrl_axis_tvalid, 1'b0);
      @(posedge clk);
      #1;
      check_counters("t2");

      // 3: untagged frame dropped without back-pressure
      send_pkt(16'h0800, 16'h0800, 8'h11, 16'h10E1, 12'd0, 3, CLS_DROP, w);
      check("t3_no_stall", w, 0);
      check("t3_idle", dut.state_q, ST_IDLE);
      check_counters("t3");

      // 4: data path stalled for 5 cycles mid-packet
      fork
         send_pkt(16'h8100, 16'h0800, 8'h11, 16'h1234, 12'd2, 3, CLS_DATA, w);
         begin
            @(posedge clk);
            #1;
            m_data_axis_tready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               if (m_data_axis_tvalid) check("t4_bp_tready", s_axis_tready, 1'b0);
               @(posedge clk);
               #1;
            end
            m_data_axis_tready = 1'b1;
         end
      join
      check("t4_stalled", w > 0, 1'b1);
      check_counters("t4");

      // 5: reset while beat 2 of a control packet is offered
      b.is_ctrl = 1'b1;
      b.data    = make_hdr(16'h8100, 16'h0800, 8'h11, 16'hF1F2, 12'd7);
      b.keep    = '1;
      b.user    = rand_user();
      b.last    = 1'b0;
      send_beat(b, 1'b1, w);
      s_axis_tdata  = rand_data();
      s_axis_tkeep  = '1;
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b1;
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("t5_ctrl_vld", m_ctrl_axis_tvalid, 1'b0);
      check("t5_data_vld", m_data_axis_tvalid, 1'b0);
      check("t5_s_tready", s_axis_tready, 1'b0);
      exp_ctrl = 0;
      exp_data = 0;
      exp_drop = 0;
      check_counters("t5_rst");
      exp_q.delete();
      s_axis_tvalid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      b.is_ctrl = 1'b0;
      b.data    = rand_data();
      b.keep    = 64'h0000_0000_0000_FFFF;
      b.user    = rand_user();
      b.last    = 1'b1;
      send_beat(b, 1'b0, w);
      exp_drop = sat_inc(exp_drop);
      check("t5_idle", dut.state_q, ST_IDLE);
      check_counters("t5_tail");

      // 6: control counter saturates at all-ones
      for (int i = 0; i < CNT_MAX; i++) begin
         send_pkt(16'h8100, 16'h0800, 8'h11, 16'hF1F2, 12'd3, 1, CLS_CTRL, w);
      end
      check("t6_ctrl_full", ctrl_pkt_cnt, CNT_MAX);
      send_pkt(16'h8100, 16'h0800, 8'h11, 16'hF1F2, 12'd3, 1, CLS_CTRL, w);
      check("t6_ctrl_sat", ctrl_pkt_cnt, CNT_MAX);
      check_counters("t6");

      t = 0;
      while (exp_q.size() != 0 && t < 20) begin
         @(posedge clk);
         t++;
      end
      check("drain_empty", exp_q.size(), 0);
      repeat (2) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
